pc_seq: RTL and testbench

Parametrised program-counter sequencer for the accumulator core, the next generation of the fixed 5-bit counter plus fetch pipeline register. It holds the fetch address and generates the instruction-memory read strobe. It supports absolute jumps, signed relative branches, stall, and an optional call/return address stack. A built-in second stage presents a one-cycle-delayed copy of address and strobe to decode.

---
 rtl/pc_seq.sv | 128 ++++++++++++
 tb/tb_pc_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with fetch strobe and a one-cycle
// decode pipeline stage. Supports absolute jumps, signed relative branches
// and stall. The call/return address stack is built only when the
// PC_STACK_EN macro is defined. Without it, call acts as load, ret acts as
// a plain increment, and sp/overflow/underflow are tied to zero.
module pc_seq #(
  parameter int                 WIDTH    = 5,
  parameter int                 DEPTH    = 4,
  parameter logic [WIDTH-1:0]   RESET_PC = '0,
  localparam int                SPW      = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  input  logic             branch,
  input  logic [WIDTH-1:0] offset,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic             rmem,
  output logic [WIDTH-1:0] pc_q,
  output logic             rmem_q,
  output logic [SPW-1:0]   sp,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_nxt;

`ifdef PC_STACK_EN
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] stack [DEPTH];
  logic [IW-1:0]    push_idx;
  logic [IW-1:0]    pop_idx;
  logic             do_push;
  logic             do_pop;
  logic             ovf_set;
  logic             unf_set;

  assign push_idx = IW'(sp);
  assign pop_idx  = IW'(sp - SPW'(1));
`endif

  // Next-PC selection and stack control, resolved by strict priority.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    pc_inc = pc + WIDTH'(1);
    pc_nxt = pc_inc;
`ifdef PC_STACK_EN
    do_push = 1'b0;
    do_pop  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
`endif
    if (stall) begin
      pc_nxt = pc;
    end else if (ret) begin
`ifdef PC_STACK_EN
      if (sp != '0) begin
        pc_nxt = stack[pop_idx];
        do_pop = 1'b1;
      end else begin
        unf_set = 1'b1;
      end
`endif
    end else if (call) begin
      pc_nxt = load_addr;
`ifdef PC_STACK_EN
      if (sp != SPW'(DEPTH)) do_push = 1'b1;
      else                   ovf_set = 1'b1;
`endif
    end else if (load) begin
      pc_nxt = load_addr;
    end else if (branch) begin
      pc_nxt = pc + offset;
    end
  end

  // PC, strobe and the decode pipeline stage.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others (pc_q gets the old pc).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      rmem   <= 1'b0;
      pc_q   <= '0;
      rmem_q <= 1'b0;
    end else begin
      pc     <= pc_nxt;
      rmem   <= !stall;
      pc_q   <= pc;
      rmem_q <= rmem;
    end
  end

`ifdef PC_STACK_EN
  // Stack pointer and sticky error flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_pop)       sp <= sp - SPW'(1);
      else if (do_push) sp <= sp + SPW'(1);
      if (ovf_set) overflow  <= 1'b1;
      if (unf_set) underflow <= 1'b1;
    end
  end

  // Return-address storage; the wrapped pc+1 is pushed.
  // NOTE: storage is deliberately not reset; only entries below sp are ever
  // read, so clearing it would cost reset fan-out for no behaviour.
  always_ff @(posedge clock) begin
    if (do_push) stack[push_idx] <= pc_inc;
  end
`else
  assign sp        = '0;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq (WIDTH=5, DEPTH=4). Expected
// values are hand-computed; where the stack option changes results, both
// outcomes are listed and selected by PC_STACK_EN.
module tb_pc_seq;

`ifdef PC_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       stall, load, branch, call, ret;
  logic [4:0] load_addr, offset;
  logic [4:0] pc, pc_q;
  logic       rmem, rmem_q;
  logic [2:0] sp;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  pc_seq #(.WIDTH(5), .DEPTH(4), .RESET_PC(5'd0)) dut (
    .clock(clock), .reset(reset), .stall(stall), .load(load),
    .load_addr(load_addr), .branch(branch), .offset(offset),
    .call(call), .ret(ret), .pc(pc), .rmem(rmem), .pc_q(pc_q),
    .rmem_q(rmem_q), .sp(sp), .overflow(overflow), .underflow(underflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall = 0; load = 0; branch = 0; call = 0; ret = 0;
    load_addr = '0; offset = '0;
  endtask

  // One rising edge, then settle 1ns so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic jump(input logic [4:0] a);
    load = 1; load_addr = a;
    tick();
  endtask

  task automatic do_call(input logic [4:0] a);
    call = 1; load_addr = a;
    tick();
  endtask

  task automatic do_ret();
    ret = 1;
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #3;
    check("rst_pc", pc, 0);
    check("rst_rmem", rmem, 0);
    check("rst_pc_q", pc_q, 0);
    check("rst_rmem_q", rmem_q, 0);
    check("rst_sp", sp, 0);
    check("rst_flags", {overflow, underflow}, 0);
    @(negedge clock);
    reset = 1'b1;

    // Free-running count from RESET_PC
    tick();
    check("cnt1_pc", pc, 1);
    check("cnt1_rmem", rmem, 1);
    check("cnt1_pc_q", pc_q, 0);
    check("cnt1_rmem_q", rmem_q, 0);
    tick();
    check("cnt2_pc", pc, 2);
    check("cnt2_pc_q", pc_q, 1);
    check("cnt2_rmem_q", rmem_q, 1);
    for (int i = 0; i < 5; i++) tick();
    check("cnt7_pc", pc, 7);

    // Absolute load
    jump(5'd15);
    check("load_pc", pc, 15);
    check("load_pc_q", pc_q, 7);
    tick();
    check("load_next_pc", pc, 16);
    check("load_next_pc_q", pc_q, 15);

    // Relative branches, backward and wrapping forward
    jump(5'd10);
    branch = 1; offset = 5'b11101;
    tick();
    check("branch_back", pc, 7);
    jump(5'd30);
    branch = 1; offset = 5'b00101;
    tick();
    check("branch_wrap", pc, 3);

    // Increment wrap 31 -> 0
    jump(5'd31);
    tick();
    check("inc_wrap_pc", pc, 0);
    check("inc_wrap_pc_q", pc_q, 31);

    // Call then return
    jump(5'd4);
    do_call(5'd20);
    check("call_pc", pc, 20);
    check("call_sp", sp, STK ? 1 : 0);
    tick();
    tick();
    check("pre_ret_pc", pc, 22);
    do_ret();
    check("ret_pc", pc, STK ? 5 : 23);
    check("ret_sp", sp, 0);

    // Five calls: fourth pushes wrapped 31+1=0, fifth overflows
    jump(5'd1);
    do_call(5'd11);
    do_call(5'd21);
    do_call(5'd31);
    do_call(5'd9);
    check("call4_pc", pc, 9);
    check("call4_sp", sp, STK ? 4 : 0);
    check("call4_ovf", overflow, 0);
    do_call(5'd19);
    check("call5_pc", pc, 19);
    check("call5_sp", sp, STK ? 4 : 0);
    check("call5_ovf", overflow, STK ? 1 : 0);

    // Five returns: LIFO 0,22,12,2 then underflow with increment
    do_ret();
    check("ret1_pc", pc, STK ? 0 : 20);
    check("ret1_sp", sp, STK ? 3 : 0);
    do_ret();
    check("ret2_pc", pc, STK ? 22 : 21);
    do_ret();
    check("ret3_pc", pc, STK ? 12 : 22);
    do_ret();
    check("ret4_pc", pc, STK ? 2 : 23);
    check("ret4_sp", sp, 0);
    check("ret4_unf", underflow, 0);
    do_ret();
    check("ret5_pc", pc, STK ? 3 : 24);
    check("ret5_unf", underflow, STK ? 1 : 0);

    // call and ret together: ret wins, push is not performed
    do_call(5'd25);
    check("pre_cr_pc", pc, 25);
    check("pre_cr_sp", sp, STK ? 1 : 0);
    call = 1; ret = 1; load_addr = 5'd7;
    tick();
    check("cr_pc", pc, STK ? 4 : 26);
    check("cr_sp", sp, 0);

    // Stall three cycles at pc=9; stall outranks a concurrent load
    jump(5'd9);
    stall = 1;
    tick();
    check("stall1_pc", pc, 9);
    check("stall1_rmem", rmem, 0);
    check("stall1_rmem_q", rmem_q, 1);
    stall = 1; load = 1; load_addr = 5'd3;
    tick();
    check("stall2_pc", pc, 9);
    check("stall2_pc_q", pc_q, 9);
    check("stall2_rmem_q", rmem_q, 0);
    stall = 1;
    tick();
    check("stall3_pc", pc, 9);
    check("stall3_rmem", rmem, 0);
    check("pre_rst_ovf", overflow, STK ? 1 : 0);

    // Asynchronous reset mid-stall, between edges
    stall = 1;
    #2;
    reset = 1'b0;
    #1;
    check("arst_pc", pc, 0);
    check("arst_rmem", rmem, 0);
    check("arst_pc_q", pc_q, 0);
    check("arst_sp", sp, 0);
    check("arst_flags", {overflow, underflow}, 0);
    @(negedge clock);
    idle();
    reset = 1'b1;
    tick();
    check("rel1_pc", pc, 1);
    check("rel1_rmem", rmem, 1);
    tick();
    check("rel2_pc", pc, 2);
    check("rel2_pc_q", pc_q, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
